// File: rtl/cordic_pkg.sv
// Shared CORDIC angle-format constants and arctangent table generation.
// Latency: none (constants and elaboration-time functions only).
// Backpressure: not applicable.
package cordic_pkg;

    // Angles are Q2.F radians with F = width - 2.
    function automatic int angle_frac_bits(input int width);
        return width - 2;
    endfunction

    // round(atan(2^-i) * 2^frac), evaluated at elaboration time.
    // Uses pi/4 for i == 0 and the Taylor series for i >= 1, where |x| <= 0.5 converges quickly.
    function automatic int atan_entry(input int i, input int frac);
        real x;
        real term;
        real sum;
        real scale;
        if (i == 0) begin
            sum = 0.78539816339744831;
        end else begin
            x = 1.0;
            for (int k = 0; k < i; k++) x = x / 2.0;
            term = x;
            sum  = 0.0;
            for (int k = 0; k < 40; k++) begin
                if (k % 2 == 0) sum = sum + term / real'(2 * k + 1);
                else            sum = sum - term / real'(2 * k + 1);
                term = term * x * x;
            end
        end
        scale = 1.0;
        for (int k = 0; k < frac; k++) scale = scale * 2.0;
        return $rtoi(sum * scale + 0.5);
    endfunction

    localparam int ANGLE_FRAC_BITS_8 = 6;

    // Reference table for the 8-bit angle format.
    localparam int ATAN8 [0:7] = '{50, 30, 16, 8, 4, 2, 1, 0};

endpackage

// File: rtl/cordic_atan_rom.sv
// Combinational lookup of the micro-rotation angle atan(2^-iter) for the current iteration.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; out-of-range iteration indices return 0.
module cordic_atan_rom
    import cordic_pkg::*;
#(
    parameter int BIT_WIDTH  = 8,
    parameter int ITERATIONS = BIT_WIDTH,
    parameter int IW         = $clog2(ITERATIONS + 1)
) (
    input  logic [IW-1:0]        iter,
    output logic [BIT_WIDTH-1:0] angle
);

    localparam int FRAC = angle_frac_bits(BIT_WIDTH);

    logic [BIT_WIDTH-1:0] table_q [0:ITERATIONS-1];

    for (genvar g = 0; g < ITERATIONS; g++) begin : g_tbl
        localparam int VAL = atan_entry(g, FRAC);
        assign table_q[g] = VAL[BIT_WIDTH-1:0];
    end

    // Select the table entry matching iter; anything past the table reads as zero.
    always_comb begin
        angle = '0;
        for (int i = 0; i < ITERATIONS; i++) begin
            if (iter == IW'(i)) angle = table_q[i];
        end
    end

endmodule

// File: rtl/cordic_comp.sv
// CORDIC rotation-mode z-path: loads an angle in reset, then one micro-rotation per clock toward zero.
// Latency: final residual ITERATIONS edges after the first edge with rst high; output is registered.
// Backpressure: none; free-running after reset release, holds the result until the next reset.
module cordic_comp
    import cordic_pkg::*;
#(
    parameter int BIT_WIDTH  = 8,
    parameter int ITERATIONS = BIT_WIDTH
) (
    input  logic [BIT_WIDTH-1:0] z_initial_in,
    input  logic                 rst,
    input  logic                 clk,
    output logic [BIT_WIDTH-1:0] z_out
);

    localparam int          IW        = $clog2(ITERATIONS + 1);
    localparam logic [IW-1:0] ITER_DONE = IW'(ITERATIONS);

    logic [BIT_WIDTH-1:0] z_current;
    logic [IW-1:0]        iter;
    logic [BIT_WIDTH-1:0] atan_val;

    cordic_atan_rom #(
        .BIT_WIDTH  (BIT_WIDTH),
        .ITERATIONS (ITERATIONS),
        .IW         (IW)
    ) u_rom (
        .iter  (iter),
        .angle (atan_val)
    );

    // Reload on reset; otherwise rotate against the residual's sign until all iterations are spent.
    // A zero residual counts as non-negative, so it subtracts.
    always_ff @(posedge clk) begin
        if (!rst) begin
            z_current <= z_initial_in;
            iter      <= '0;
        end else if (iter < ITER_DONE) begin
            if (z_current[BIT_WIDTH-1]) z_current <= z_current + atan_val;
            else                        z_current <= z_current - atan_val;
            iter <= iter + IW'(1);
        end
    end

    assign z_out = z_current;

endmodule

// File: tb/tb_cordic_comp.sv
// Directed self-checking bench for cordic_comp (8-bit angles, 8 iterations).
// Latency: checks each edge's residual against hand-computed sequences.
// Backpressure: not applicable.
module tb_cordic_comp;

    logic       clk;
    logic       rst;
    logic [7:0] z_initial_in;
    logic [7:0] z_out;

    int n_vec  = 0;
    int n_fail = 0;

    cordic_comp #(.BIT_WIDTH(8), .ITERATIONS(8)) dut (
        .z_initial_in (z_initial_in),
        .rst          (rst),
        .clk          (clk),
        .z_out        (z_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]  z_init;
        logic [71:0] seq;   // nine expected z_out bytes, first at the top
    } vec_t;

    vec_t vecs [0:4];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%02h), want %0d (0x%02h)", name, $signed(act), act, $signed(exp), exp);
        end
    endtask

    initial begin
        vecs[0] = '{8'h43, {8'h43, 8'h11, 8'hF3, 8'h03, 8'hFB, 8'hFF, 8'h01, 8'h00, 8'h00}};
        vecs[1] = '{8'hBD, {8'hBD, 8'hEF, 8'h0D, 8'hFD, 8'h05, 8'h01, 8'hFF, 8'h00, 8'h00}};
        vecs[2] = '{8'h00, {8'h00, 8'hCE, 8'hEC, 8'hFC, 8'h04, 8'h00, 8'hFE, 8'hFF, 8'hFF}};
        vecs[3] = '{8'h1E, {8'h1E, 8'hEC, 8'h0A, 8'hFA, 8'h02, 8'hFE, 8'h00, 8'hFF, 8'hFF}};
        vecs[4] = '{8'h9C, {8'h9C, 8'hCE, 8'hEC, 8'hFC, 8'h04, 8'h00, 8'hFE, 8'hFF, 8'hFF}};

        rst          = 1'b0;
        z_initial_in = 8'h00;
        #2;

        // Table-driven full runs, plus two hold cycles after completion.
        for (int v = 0; v < 5; v++) begin
            rst          = 1'b0;
            z_initial_in = vecs[v].z_init;
            step();
            check($sformatf("vec%0d_reset", v), z_out, vecs[v].seq[71:64]);
            rst = 1'b1;
            for (int k = 1; k <= 8; k++) begin
                step();
                check($sformatf("vec%0d_iter%0d", v, k), z_out, vecs[v].seq[8*(8-k) +: 8]);
            end
            for (int h = 0; h < 2; h++) begin
                step();
                check($sformatf("vec%0d_hold%0d", v, h), z_out, vecs[v].seq[7:0]);
            end
        end

        // Reset held: z_out follows each sampled value, no iteration.
        rst          = 1'b0;
        z_initial_in = 8'd10; step(); check("held_rst_10", z_out, 8'd10);
        z_initial_in = 8'd20; step(); check("held_rst_20", z_out, 8'd20);
        z_initial_in = 8'd30; step(); check("held_rst_30", z_out, 8'd30);

        // Reset mid-run: reload 0 after three iterations of 67, then restart.
        z_initial_in = 8'h43; step(); check("abort_load", z_out, 8'h43);
        rst = 1'b1;
        step(); check("abort_it1", z_out, 8'h11);
        step(); check("abort_it2", z_out, 8'hF3);
        step(); check("abort_it3", z_out, 8'h03);
        rst          = 1'b0;
        z_initial_in = 8'h00;
        step(); check("abort_reload", z_out, 8'h00);
        rst = 1'b1;
        step(); check("restart_it1", z_out, 8'hCE);
        step(); check("restart_it2", z_out, 8'hEC);

        // Input changes while running have no effect; result stays put afterwards.
        rst          = 1'b0;
        z_initial_in = 8'h43;
        step(); check("ign_load", z_out, 8'h43);
        rst = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            z_initial_in = 8'($urandom_range(0, 255));
            step();
            check($sformatf("ign_iter%0d", k), z_out, vecs[0].seq[8*(8-k) +: 8]);
        end
        for (int h = 0; h < 6; h++) begin
            z_initial_in = 8'($urandom_range(0, 255));
            step();
            check($sformatf("ign_hold%0d", h), z_out, 8'h00);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
